// File: rtl/button_debouncer_pkg.sv
// rtl/button_debouncer_pkg.sv - shared FSM encoding and board defaults for the button debouncer
package button_debouncer_pkg;

  // Debounce FSM: two settled states and two qualifying states, one per polarity
  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // 20 ms of stability at the 50 MHz board clock
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_CNT_W         = 20;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// rtl/button_debouncer_sync_2ff.sv - two-flop synchroniser for one asynchronous pin
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  // Shift the raw pin through two flops; only r_s2 is safe to use downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronise, debounce and edge-detect a bouncing push-button
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
);

  // Last count value in a WAIT state; reaching it with the input still held commits
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_s2;
  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_rise_next;
  logic             w_fall_next;
  logic             w_level_next;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (btn_in),
    .o_q   (w_s2)
  );

  // State and stability counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: leave a settled state on any difference, commit after a full stable run
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      IDLE_LOW: begin
        w_cnt_next = '0;
        if (w_s2) w_state_next = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!w_s2)                 w_state_next = IDLE_LOW;
        else if (r_cnt == CNT_LAST) w_state_next = IDLE_HIGH;
        else                        w_cnt_next   = r_cnt + CNT_W'(1);
      end
      IDLE_HIGH: begin
        w_cnt_next = '0;
        if (!w_s2) w_state_next = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (w_s2)                   w_state_next = IDLE_HIGH;
        else if (r_cnt == CNT_LAST) w_state_next = IDLE_LOW;
        else                        w_cnt_next   = r_cnt + CNT_W'(1);
      end
      default: begin
        w_state_next = IDLE_LOW;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Commit decode: a pulse only on the cycle a WAIT state completes its run
  always_comb begin
    w_rise_next  = (r_state == WAIT_HIGH) && w_s2  && (r_cnt == CNT_LAST);
    w_fall_next  = (r_state == WAIT_LOW)  && !w_s2 && (r_cnt == CNT_LAST);
    w_level_next = r_level;
    if (w_rise_next) w_level_next = 1'b1;
    if (w_fall_next) w_level_next = 1'b0;
  end

  // Registered outputs so the level and pulses are glitch-free at the pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_level_next;
      r_rise  <= w_rise_next;
      r_fall  <= w_fall_next;
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
module tb_button_debouncer;

  localparam int STABLE = 8;
  localparam int CW     = 4;

  logic clk;
  logic rst_n;
  logic btn_in;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;

  int checks   = 0;
  int failures = 0;

  // Reference model: level flips once the two-cycle-delayed input has
  // disagreed with it for STABLE+1 consecutive samples (one sample to
  // leave the settled state, STABLE samples counted while waiting).
  logic hist[$];
  logic m_level;
  int   run;
  int   n_edge;
  int   rise_cnt, fall_cnt, rise_edge, fall_edge;

  button_debouncer #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back(1'b0);
    hist.push_back(1'b0);
    m_level = 1'b0;
    run     = 0;
  endtask

  task automatic clear_stats();
    n_edge    = 0;
    rise_cnt  = 0;
    fall_cnt  = 0;
    rise_edge = -1;
    fall_edge = -1;
  endtask

  task automatic tick(input logic b);
    logic s2s;
    logic exp_rise;
    logic exp_fall;
    btn_in = b;
    @(posedge clk);
    n_edge++;
    hist.push_back(b);
    s2s      = hist.pop_front();
    exp_rise = 1'b0;
    exp_fall = 1'b0;
    if (s2s != m_level) begin
      run++;
      if (run == STABLE + 1) begin
        m_level  = s2s;
        exp_rise = s2s;
        exp_fall = !s2s;
        run      = 0;
      end
    end else begin
      run = 0;
    end
    #1;
    check("level", btn_level, m_level);
    check("rise", btn_rise, exp_rise);
    check("fall", btn_fall, exp_fall);
    check("cnt_bound", (dut.r_cnt <= CW'(STABLE - 1)), 1'b1);
    if (btn_rise) begin rise_cnt++; rise_edge = n_edge; end
    if (btn_fall) begin fall_cnt++; fall_edge = n_edge; end
  endtask

  task automatic hold(input logic b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  initial begin
    int seg_start;
    int len;
    logic v;

    // Reset state
    btn_in = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #12;
    check("reset_level", btn_level, 1'b0);
    check("reset_rise", btn_rise, 1'b0);
    check("reset_fall", btn_fall, 1'b0);
    rst_n = 1'b1;
    hold(1'b0, 5);

    // Clean press: level and single rise land at edge 11 after the change
    clear_stats();
    hold(1'b1, 20);
    check("press_rise_edge", rise_edge, 11);
    check("press_rise_cnt", rise_cnt, 1);
    check("press_fall_cnt", fall_cnt, 0);
    check("press_level", btn_level, 1'b1);

    // Release: single fall at edge 11
    clear_stats();
    hold(1'b0, 20);
    check("release_fall_edge", fall_edge, 11);
    check("release_fall_cnt", fall_cnt, 1);
    check("release_rise_cnt", rise_cnt, 0);
    check("release_level", btn_level, 1'b0);

    // Bounce: 1,0,1,0 in 3-cycle segments, then hold 1
    clear_stats();
    hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3);
    check("bounce_no_pulse", rise_cnt + fall_cnt, 0);
    seg_start = n_edge;
    hold(1'b1, 20);
    check("bounce_rise_edge", rise_edge - seg_start, 11);
    check("bounce_rise_cnt", rise_cnt, 1);

    // Short glitch low for 7 cycles: rejected
    clear_stats();
    hold(1'b0, 7);
    hold(1'b1, 15);
    check("glitch7_fall_cnt", fall_cnt, 0);
    check("glitch7_level", btn_level, 1'b1);

    // 8 cycles low: s2 low on the leaving sample plus only 7 counted samples
    clear_stats();
    hold(1'b0, 8);
    hold(1'b1, 15);
    check("low8_fall_cnt", fall_cnt, 0);
    check("low8_level", btn_level, 1'b1);

    // 9 cycles low: s2 low through all 8 counted cycles, exactly one fall
    clear_stats();
    hold(1'b0, 9);
    hold(1'b1, 2);
    check("low9_fall_cnt", fall_cnt, 1);
    check("low9_fall_edge", fall_edge, 11);
    check("low9_level_dropped", m_level, 1'b0);
    hold(1'b1, 15);
    check("low9_recover_rise", rise_cnt, 1);

    // Asynchronous reset mid-cycle with btn_in=1, btn_level=1
    check("pre_reset_level", btn_level, 1'b1);
    hold(1'b1, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_level", btn_level, 1'b0);
    check("async_reset_rise", btn_rise, 1'b0);
    check("async_reset_fall", btn_fall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    hold(1'b1, 16);
    check("post_reset_rise_edge", rise_edge, 11);
    check("post_reset_rise_cnt", rise_cnt, 1);

    // Randomised bouncing segments against the model
    for (int s = 0; s < 60; s++) begin
      v   = 1'($urandom_range(0, 1));
      len = (s % 4 == 3) ? $urandom_range(9, 14) : $urandom_range(1, 10);
      hold(v, len);
    end
    hold(1'b0, 15);
    check("final_level", btn_level, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
